// File: rtl/alu_div_pkg.sv
// alu_div_pkg: shared encodings for the iterative RV32M divide unit.
// The operation encoding, the FSM state encoding and the default operand
// width (tied to the core instruction width) live here.
package alu_div_pkg;

    localparam int instWidth    = 32;
    localparam int XLEN_DEFAULT = instWidth;

    // Operation select as issued by the decoder.
    typedef enum logic [1:0] {
        divDIV  = 2'b00,
        divDIVU = 2'b01,
        divREM  = 2'b10,
        divREMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_BUSY  = 2'b01,
        S_FIXUP = 2'b10,
        S_DONE  = 2'b11
    } div_state_e;

    // DIV and REM are the signed flavours (bit 0 clear).
    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    // REM and REMU return the remainder (bit 1 set).
    function automatic logic op_is_rem(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/alu_div_div_step.sv
// div_step: one combinational radix-2 restoring iteration.
// Shifts the next dividend bit into the partial remainder and subtracts the
// divisor when it fits. Kept separate so the loop can later be unrolled.
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic            q_msb_i,
    input  logic [XLEN-1:0] div_i,
    output logic [XLEN-1:0] rem_o,
    output logic            q_bit_o
);

    logic [XLEN:0]   shifted;
    logic [XLEN-1:0] diff;

    // Trial subtraction on the XLEN+1-bit shifted remainder; the low XLEN bits
    // of the difference are exact whenever it is non-negative.
    always_comb begin
        shifted = {rem_i, q_msb_i};
        diff    = shifted[XLEN-1:0] - div_i;
        q_bit_o = (shifted >= {1'b0, div_i});
        rem_o   = q_bit_o ? diff : shifted[XLEN-1:0];
    end

endmodule

// File: rtl/alu_div.sv
// alu_div: iterative RV32M DIV/DIVU/REM/REMU unit, one quotient bit per cycle.
// Request and response are valid/ready handshakes; one result entry is held.
// Optional feature macro DIV_FASTPATH_EN: divide-by-zero, signed overflow and
// divide-by-one finish at accept and go straight to DONE.
module alu_div
    import alu_div_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      div_op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] div_result
);

    localparam int            CW       = $clog2(XLEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

    div_state_e      state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic            rem_sel_q, neg_quo_q, neg_rem_q;
    logic [XLEN-1:0] quo_q, dvs_q, rem_q, res_q;
    logic            accept, in_signed, fast_hit;
    logic [XLEN-1:0] step_rem;
    logic            step_bit;

    // Two's-complement negate when c is set.
    function automatic logic [XLEN-1:0] neg_if(input logic c, input logic [XLEN-1:0] x);
        return c ? ((~x) + XLEN'(1)) : x;
    endfunction

    assign req_ready  = (state_q == S_IDLE);
    assign rsp_valid  = (state_q == S_DONE);
    assign div_result = res_q;
    assign accept     = req_valid && req_ready;
    assign in_signed  = op_is_signed(div_op);

`ifdef DIV_FASTPATH_EN
    logic [XLEN-1:0] fast_res;
    logic            fp_zero, fp_one, fp_ovf;

    // Detect the special cases on the incoming operands and form their result.
    always_comb begin
        fp_zero  = (divisor == '0);
        fp_one   = (divisor == XLEN'(1));
        fp_ovf   = in_signed && (dividend == {1'b1, {(XLEN-1){1'b0}}}) && (divisor == '1);
        fast_hit = fp_zero || fp_one || fp_ovf;
        if (op_is_rem(div_op)) fast_res = fp_zero ? dividend : '0;
        else                   fast_res = fp_zero ? '1 : dividend;
    end
`else
    assign fast_hit = 1'b0;
`endif

    div_step #(.XLEN(XLEN)) u_step (
        .rem_i   (rem_q),
        .q_msb_i (quo_q[XLEN-1]),
        .div_i   (dvs_q),
        .rem_o   (step_rem),
        .q_bit_o (step_bit)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; flush overrides every transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = fast_hit ? S_DONE : S_BUSY;
            S_BUSY:  if (cnt_q == '0) state_d = S_FIXUP;
            S_FIXUP: state_d = S_DONE;
            S_DONE:  if (rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush) state_d = S_IDLE;
    end

    // Datapath: operand capture, iteration, sign fixup and result hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            res_q <= '0;
        end else if (flush) begin
            cnt_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (accept) begin
                    rem_sel_q <= op_is_rem(div_op);
                    neg_quo_q <= in_signed && (dividend[XLEN-1] ^ divisor[XLEN-1]);
                    neg_rem_q <= in_signed && dividend[XLEN-1];
                    quo_q     <= neg_if(in_signed && dividend[XLEN-1], dividend);
                    dvs_q     <= neg_if(in_signed && divisor[XLEN-1], divisor);
                    rem_q     <= '0;
                    cnt_q     <= CNT_LAST;
`ifdef DIV_FASTPATH_EN
                    if (fast_hit) res_q <= fast_res;
`endif
                end
                S_BUSY: begin
                    rem_q <= step_rem;
                    quo_q <= {quo_q[XLEN-2:0], step_bit};
                    if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
                end
                // A zero divisor leaves the all-ones quotient un-negated.
                S_FIXUP: res_q <= rem_sel_q ? neg_if(neg_rem_q, rem_q)
                                            : neg_if(neg_quo_q && (dvs_q != '0), quo_q);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_div.sv
// tb_alu_div: directed and swept checks of alu_div against an arithmetic
// reference of the RV32M divide/remainder rules.
module tb_alu_div;

`ifdef DIV_FASTPATH_EN
    localparam bit FAST_EN = 1'b1;
`else
    localparam bit FAST_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, flush, req_valid, req_ready, rsp_valid, rsp_ready;
    logic [1:0]  div_op;
    logic [31:0] dividend, divisor, div_result;

    int          vectors = 0;
    int          miscompares = 0;
    logic        exp_pending = 1'b0;
    logic [31:0] exp_res = '0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
    } vec_t;

    alu_div #(.XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .div_op     (div_op),
        .dividend   (dividend),
        .divisor    (divisor),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .div_result (div_result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // RISC-V divide semantics from plain arithmetic.
    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb, qs, rs;
        logic [31:0] quo, remv;
        sa = a;
        sb = b;
        if (b == 32'd0) begin
            quo = 32'hFFFF_FFFF; remv = a;
        end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            quo = a; remv = 32'd0;
        end else if (!op[0]) begin
            qs = sa / sb; rs = sa % sb; quo = qs; remv = rs;
        end else begin
            quo = a / b; remv = a % b;
        end
        return op[1] ? remv : quo;
    endfunction

    function automatic int exp_latency(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bit special;
        special = (b == 32'd0) || (b == 32'd1) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        return (FAST_EN && special) ? 1 : 34;
    endfunction

    // Compare process: every cycle a result is presented it must be expected and match the model.
    always @(negedge clk) begin
        if (!rst && rsp_valid) begin
            check("spurious_rsp_valid", {31'b0, rsp_valid}, {31'b0, exp_pending});
            check("ready_in_done", {31'b0, req_ready}, 32'd0);
            if (exp_pending) check("model_result", div_result, exp_res);
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_req_ready"}, {31'b0, req_ready}, 32'd1);
        check({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'd0);
        check({tag, "_result"}, div_result, 32'd0);
    endtask

    // Wait for ready, present one request and return just after the accept edge.
    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_wait", {31'b0, req_ready}, 32'd1);
        div_op = op; dividend = a; divisor = b; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        exp_res = model(op, a, b);
        exp_pending = 1'b1;
        check("busy_req_ready", {31'b0, req_ready}, 32'd0);
    endtask

    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit use_lit, input logic [31:0] lit);
        int lat;
        start_op(op, a, b);
        lat = 1;
        while (!rsp_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(exp_latency(op, a, b)));
        if (use_lit) check("literal_result", div_result, lit);
        if (rsp_ready) begin
            @(posedge clk);
            #1;
            exp_pending = 1'b0;
            check("post_hs_rsp_valid", {31'b0, rsp_valid}, 32'd0);
            check("post_hs_req_ready", {31'b0, req_ready}, 32'd1);
        end
    endtask

    task automatic reset_midop(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input int k);
        start_op(op, a, b);
        repeat (k) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        exp_pending = 1'b0;
        check_reset_vals("midop_reset");
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[16];
        logic [31:0] held;
        logic [1:0]  rop;
        logic [31:0] ra, rb;

        tbl = '{
            '{2'b01, 32'd100,        32'd7,          32'd14},
            '{2'b11, 32'd100,        32'd7,          32'd2},
            '{2'b00, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2},
            '{2'b10, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE},
            '{2'b10, 32'd100,        32'hFFFF_FFF9,  32'd2},
            '{2'b00, 32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2},
            '{2'b10, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'hFFFF_FFFE},
            '{2'b00, 32'd5,          32'd0,          32'hFFFF_FFFF},
            '{2'b10, 32'd5,          32'd0,          32'd5},
            '{2'b01, 32'd5,          32'd0,          32'hFFFF_FFFF},
            '{2'b11, 32'hFFFF_FF9C,  32'd0,          32'hFFFF_FF9C},
            '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000},
            '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0},
            '{2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'd1},
            '{2'b11, 32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'd1},
            '{2'b00, 32'hFFFF_FF9C,  32'd1,          32'hFFFF_FF9C}
        };

        rst = 1'b1; flush = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
        div_op = 2'b00; dividend = '0; divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors with hand-computed results.
        foreach (tbl[i]) do_op(tbl[i].op, tbl[i].a, tbl[i].b, 1'b1, tbl[i].r);

        // Result stall: held stable with the request side closed, then released.
        rsp_ready = 1'b0;
        do_op(2'b01, 32'd1000, 32'd33, 1'b1, 32'd30);
        held = div_result;
        repeat (10) begin
            @(negedge clk);
            check("stall_result", div_result, 32'd30);
            check("stall_req_ready", {31'b0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        exp_pending = 1'b0;
        check("release_req_ready", {31'b0, req_ready}, 32'd1);
        check("release_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("release_result_kept", div_result, held);
        do_op(2'b11, 32'd1000, 32'd33, 1'b1, 32'd10);

        // Flush mid-iteration with a competing request: back to IDLE, nothing accepted.
        start_op(2'b00, 32'd12345, 32'd77);
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1; req_valid = 1'b1; div_op = 2'b01; dividend = 32'd9; divisor = 32'd3;
        @(posedge clk);
        #1;
        flush = 1'b0; req_valid = 1'b0; exp_pending = 1'b0;
        check("flush_req_ready", {31'b0, req_ready}, 32'd1);
        check("flush_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        repeat (40) @(posedge clk);
        do_op(2'b00, 32'd12345, 32'd77, 1'b1, 32'd160);

        // Flush colliding with the result handshake in DONE.
        rsp_ready = 1'b0;
        do_op(2'b10, 32'd12345, 32'd77, 1'b1, 32'd25);
        @(negedge clk);
        flush = 1'b1; rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0; exp_pending = 1'b0;
        check("flush_done_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("flush_done_req_ready", {31'b0, req_ready}, 32'd1);

        // Reset out of DONE clears the held result.
        rsp_ready = 1'b0;
        do_op(2'b01, 32'd77, 32'd7, 1'b1, 32'd11);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        exp_pending = 1'b0;
        check_reset_vals("done_reset");
        @(negedge clk);
        rst = 1'b0; rsp_ready = 1'b1;

        // Operand sweep with occasional resets mid-operation.
        for (int n = 0; n < 150; n++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 20));
                2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                3: rb = rb >> $urandom_range(8, 30);
                default: ;
            endcase
            if (n % 25 == 24) reset_midop(rop, ra, rb, $urandom_range(1, 30));
            else              do_op(rop, ra, rb, 1'b0, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
